// File: rtl/io_request_responder.sv
// rtl/io_request_responder.sv - peripheral side of the CPU I/O handshake with a debounced enter button
module io_request_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int SWITCH_WIDTH    = 16,
    parameter int DEBOUNCE_WIDTH  = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    is_input,
    input  logic                    is_output,
    input  logic [DATA_WIDTH-1:0]   output_data,
    input  logic [SWITCH_WIDTH-1:0] switches,
    input  logic                    enter_button,
    output logic                    confirmation,
    output logic [DATA_WIDTH-1:0]   input_data,
    output logic [DATA_WIDTH-1:0]   display_data,
    output logic                    waiting
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        WAIT_RELEASE = 3'd2,
        ACK          = 3'd3,
        DONE         = 3'd4
    } state_t;

    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_MAX = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                      sync1_q, btn_sync_q;
    logic                      stable_q, stable_d;
    logic                      press_q, press_d;
    logic                      release_q, release_d;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;

    state_t                    state_q, state_d;
    logic                      op_is_input_q, op_is_input_d;
    logic [DATA_WIDTH-1:0]     input_data_q, input_data_d;
    logic [DATA_WIDTH-1:0]     display_data_q, display_data_d;
    logic                      req_active;

    // The stable level only flips after the synchronized button has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        stable_d  = stable_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (btn_sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d  = btn_sync_q;
                press_d   = btn_sync_q;
                release_d = !btn_sync_q;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            btn_sync_q <= 1'b0;
            stable_q   <= 1'b0;
            cnt_q      <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            sync1_q    <= enter_button;
            btn_sync_q <= sync1_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            op_is_input_q  <= 1'b0;
            input_data_q   <= '0;
            display_data_q <= '0;
        end else begin
            state_q        <= state_d;
            op_is_input_q  <= op_is_input_d;
            input_data_q   <= input_data_d;
            display_data_q <= display_data_d;
        end
    end

    assign req_active = op_is_input_q ? is_input : is_output;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_input || is_output) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!req_active)  state_d = IDLE;
                else if (press_q) state_d = WAIT_RELEASE;
            end
            // A dropped request is deliberately ignored here so the user's press completes.
            WAIT_RELEASE: begin
                if (release_q || !stable_q) state_d = ACK;
            end
            ACK: begin
                state_d = DONE;
            end
            DONE: begin
                if (!is_input && !is_output) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        op_is_input_d  = op_is_input_q;
        input_data_d   = input_data_q;
        display_data_d = display_data_q;
        confirmation   = (state_q == ACK);
        waiting        = (state_q == WAIT_PRESS);
        if (state_q == IDLE) begin
            if (is_input) begin
                op_is_input_d = 1'b1;
            end else if (is_output) begin
                op_is_input_d  = 1'b0;
                display_data_d = output_data;
            end
        end
        if (state_q == WAIT_PRESS && req_active && press_q && op_is_input_q) begin
            input_data_d = DATA_WIDTH'(switches);
        end
    end

    assign input_data   = input_data_q;
    assign display_data = display_data_q;

endmodule

// File: tb/tb_io_request_responder.sv
// tb/tb_io_request_responder.sv - scoreboard bench for io_request_responder with randomized requests
module tb_io_request_responder;

    localparam int DW  = 32;
    localparam int SW  = 16;
    localparam int DBC = 4;
    // button edge -> 2 sync stages -> DBC stable cycles -> event -> ACK one cycle later
    localparam int CONF_LAT = 2 + DBC + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          is_input, is_output, enter_button;
    logic [DW-1:0] output_data;
    logic [SW-1:0] switches;
    logic          confirmation, waiting;
    logic [DW-1:0] input_data, display_data;

    io_request_responder #(
        .DATA_WIDTH(DW), .SWITCH_WIDTH(SW), .DEBOUNCE_WIDTH(16), .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clock(clock), .reset(reset), .is_input(is_input), .is_output(is_output),
        .output_data(output_data), .switches(switches), .enter_button(enter_button),
        .confirmation(confirmation), .input_data(input_data),
        .display_data(display_data), .waiting(waiting)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] in_val;
        logic [DW-1:0] disp_val;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_in = '0;
    logic [DW-1:0] exp_disp = '0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every confirmation pulse must match exactly one queued expectation.
    always @(negedge clock) begin
        if (reset && confirmation) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_confirmation: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("conf_input_data", input_data, e.in_val);
                check("conf_display_data", display_data, e.disp_val);
                check("conf_latency", DW'(cyc), DW'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.in_val   = exp_in;
        e.disp_val = exp_disp;
        e.cyc      = cyc + CONF_LAT;
        sb_q.push_back(e);
    endtask

    // Clean press and release; the confirmation is expected CONF_LAT cycles after release.
    task automatic press_release(input int pre, input int hold);
        tick(pre);
        enter_button = 1'b1;
        tick(hold);
        enter_button = 1'b0;
        push_expect();
    endtask

    task automatic do_txn(input bit want_in, input bit want_out, input int hold_after);
        switches    = SW'($urandom);
        output_data = $urandom;
        is_input    = want_in;
        is_output   = want_out;
        if (want_in)       exp_in   = DW'(switches);
        else if (want_out) exp_disp = output_data;
        tick(1);
        check("txn_waiting", DW'(waiting), DW'(1));
        check("txn_display_latch", display_data, exp_disp);
        output_data = $urandom;
        press_release($urandom_range(0, 4), $urandom_range(DBC + 2, 12));
        tick(CONF_LAT + 3 + hold_after);
        is_input  = 1'b0;
        is_output = 1'b0;
        tick(1 + $urandom_range(0, 2));
    endtask

    initial begin
        reset        = 1'b0;
        is_input     = 1'b0;
        is_output    = 1'b0;
        enter_button = 1'b0;
        output_data  = '0;
        switches     = '0;
        #12;
        check("rst_confirmation", DW'(confirmation), DW'(0));
        check("rst_waiting", DW'(waiting), DW'(0));
        check("rst_input_data", input_data, '0);
        check("rst_display_data", display_data, '0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick(2);

        // Directed input and output operations.
        switches  = 16'hBEEF;
        is_input  = 1'b1;
        exp_in    = 32'h0000BEEF;
        tick(1);
        check("in_waiting", DW'(waiting), DW'(1));
        press_release(0, 10);
        tick(CONF_LAT + 3);
        check("in_input_data", input_data, 32'h0000BEEF);
        is_input = 1'b0;
        tick(2);
        do_txn(1'b0, 1'b1, 0);

        // Abort from WAIT_PRESS: display is latched but no confirmation follows.
        output_data = 32'h12345678;
        is_output   = 1'b1;
        exp_disp    = 32'h12345678;
        tick(1);
        check("abort_display", display_data, 32'h12345678);
        check("abort_waiting_hi", DW'(waiting), DW'(1));
        is_output = 1'b0;
        tick(2);
        check("abort_waiting_lo", DW'(waiting), DW'(0));
        tick(5);

        // Bouncing button must not produce a press.
        switches = SW'($urandom);
        is_input = 1'b1;
        exp_in   = DW'(switches);
        tick(1);
        repeat (5) begin
            enter_button = 1'b1;
            tick(2);
            enter_button = 1'b0;
            tick(2);
        end
        tick(10);
        check("bounce_still_waiting", DW'(waiting), DW'(1));
        press_release(0, 8);
        tick(CONF_LAT + 3);
        is_input = 1'b0;
        tick(2);

        // Button already held when the request arrives.
        enter_button = 1'b1;
        tick(10);
        switches = SW'($urandom);
        is_input = 1'b1;
        exp_in   = DW'(switches);
        tick(15);
        check("held_press_waiting", DW'(waiting), DW'(1));
        enter_button = 1'b0;
        tick(10);
        press_release(0, 8);
        tick(CONF_LAT + 3);
        is_input = 1'b0;
        tick(2);

        // Request held 50 cycles past the confirmation, then a fresh one.
        do_txn(1'b1, 1'b0, 50);
        do_txn(1'b1, 1'b0, 0);

        // Randomized mix, including both requests high (input wins).
        for (int i = 0; i < 20; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            do_txn(sel != 1, sel != 0, $urandom_range(0, 6));
        end

        // Asynchronous reset while in WAIT_RELEASE.
        switches     = SW'($urandom) | 16'h0001;
        is_input     = 1'b1;
        tick(1);
        enter_button = 1'b1;
        begin
            int budget;
            budget = 30;
            while (waiting && budget > 0) begin
                tick(1);
                budget--;
            end
            check("arst_reached_release", DW'(waiting), DW'(0));
        end
        #2;
        reset = 1'b0;
        #1;
        check("arst_confirmation", DW'(confirmation), DW'(0));
        check("arst_waiting", DW'(waiting), DW'(0));
        check("arst_input_data", input_data, '0);
        check("arst_display_data", display_data, '0);
        exp_in       = '0;
        exp_disp     = '0;
        enter_button = 1'b0;
        is_input     = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        check("post_rst_waiting", DW'(waiting), DW'(0));
        do_txn(1'b1, 1'b1, 0);
        do_txn(1'b0, 1'b1, 0);

        tick(10);
        check("sb_drained", DW'(sb_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
